// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480@60 raster constants, the colour type and a small window
//   helper. The graphics stage imports this package as well, so its
//   MAX_X/MAX_Y limits always match the timing generated by vga_sync_gen.
//   No ports (package only).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  // Visible area limits seen by the graphics stage
  localparam int MAX_X = H_DISP;
  localparam int MAX_Y = V_DISP;

  // Raster counters are 10 bits wide, so a total may not exceed 1024
  localparam int CNT_W     = 10;
  localparam int CNT_RANGE = 1 << CNT_W;

  // Pixel clock divider range
  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 16;

  // 3-bit colour (one bit each for R, G, B)
  typedef logic [2:0] rgb_t;
  localparam rgb_t RGB_BLACK = 3'b000;

  // True when lo <= pos < hi_excl. Positions are carried with one spare bit
  // so that a window ending exactly at 1024 still compares correctly.
  function automatic logic in_window(input logic [CNT_W:0] pos,
                                     input logic [CNT_W:0] lo,
                                     input logic [CNT_W:0] hi_excl);
    return (pos >= lo) && (pos < hi_excl);
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// ---------------------------------------------------------------------------
// pix_tick_div
//   Divides the system clock down to a one-clk-wide pixel-rate enable.
//   A counter runs 0..DIV-1 and wraps; pix_tick is high while it sits at
//   DIV-1. With DIV=1 the counter never leaves 0, so pix_tick is a constant
//   1, including while reset is asserted.
//
//   Parameters:
//     DIV       clk cycles per pixel, 1..16
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous, active-low reset
//     pix_tick  out  pixel-rate enable, one clk wide
// ---------------------------------------------------------------------------
module pix_tick_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  // A 1-bit counter is kept even for DIV=1 so the vector is never empty
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  if ((DIV < DIV_MIN) || (DIV > DIV_MAX)) begin : g_bad_div
    $error("pix_tick_div: DIV must be in the range 1..16");
  end

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  always_comb begin
    pix_tick  = (div_cnt_q == DIV_LAST);
    div_cnt_d = pix_tick ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   640x480@60 raster timing generator with final colour blanking.
//   h_cnt/v_cnt advance once per pixel tick and keep running through the
//   blanking intervals, so pix_y covers 480..524 and downstream decodes such
//   as (pix_x==0, pix_y==481) are reachable.
//
//   Build option (macro VGA_OUT_REG_EN):
//     defined   - hsync, vsync, video_on and rgb_out are registered on
//                 pix_tick and lag pix_x/pix_y by exactly one pixel tick.
//     undefined - those outputs are combinational decodes of the counters.
//   pix_x, pix_y, pix_tick and frame_start are the same in both builds.
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous, active-low reset
//     rgb_in       in   [2:0] colour from the graphics stage
//     pix_x        out  [9:0] horizontal counter 0..H_TOTAL-1
//     pix_y        out  [9:0] vertical counter 0..V_TOTAL-1
//     hsync        out  horizontal sync (active level SYNC_POL)
//     vsync        out  vertical sync (active level SYNC_POL)
//     video_on     out  high inside the active area
//     pix_tick     out  pixel-rate enable, one clk wide
//     frame_start  out  one-tick pulse at (0,0)
//     rgb_out      out  [2:0] blanked colour to the encoder
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int   H_DISP   = vga_timing_pkg::H_DISP,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_DISP   = vga_timing_pkg::V_DISP,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   DIV      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [2:0] rgb_out
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_RANGE) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must not exceed 1024");
  end
  if (V_TOTAL > CNT_RANGE) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must not exceed 1024");
  end

  // Window edges carry one extra bit so an edge equal to 1024 is representable
  localparam logic [CNT_W:0] H_DISP_W       = (CNT_W + 1)'(H_DISP);
  localparam logic [CNT_W:0] H_SYNC_START_W = (CNT_W + 1)'(H_DISP + H_FP);
  localparam logic [CNT_W:0] H_SYNC_END_W   = (CNT_W + 1)'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_DISP_W       = (CNT_W + 1)'(V_DISP);
  localparam logic [CNT_W:0] V_SYNC_START_W = (CNT_W + 1)'(V_DISP + V_FP);
  localparam logic [CNT_W:0] V_SYNC_END_W   = (CNT_W + 1)'(V_DISP + V_FP + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             pix_tick_i;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q;
  logic [CNT_W-1:0] v_cnt_d;
  logic [CNT_W:0]   h_pos;
  logic [CNT_W:0]   v_pos;

  logic             hsync_d;
  logic             vsync_d;
  logic             video_on_d;
  rgb_t             rgb_out_d;

  pix_tick_div #(
    .DIV (DIV)
  ) u_pix_tick_div (
    .clk      (clk),
    .rst_n    (reset),
    .pix_tick (pix_tick_i)
  );

  // Raster counters: h_cnt steps on each pixel tick; at end of line it wraps
  // and v_cnt steps, and v_cnt wraps on the very same tick at end of frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_pos = {1'b0, h_cnt_q};
  assign v_pos = {1'b0, v_cnt_q};

  // Zero-latency decode of the current raster position
  always_comb begin
    video_on_d = (h_pos < H_DISP_W) && (v_pos < V_DISP_W);
    hsync_d    = in_window(h_pos, H_SYNC_START_W, H_SYNC_END_W) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = in_window(v_pos, V_SYNC_START_W, V_SYNC_END_W) ? SYNC_POL : ~SYNC_POL;
    rgb_out_d  = video_on_d ? rgb_t'(rgb_in) : RGB_BLACK;
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign pix_tick    = pix_tick_i;
  assign frame_start = pix_tick_i && (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef VGA_OUT_REG_EN
  logic hsync_q;
  logic vsync_q;
  logic video_on_q;
  rgb_t rgb_out_q;

  // Capturing the decode on the pixel tick delays these outputs by one pixel,
  // giving the graphics stage a full pixel period for its colour logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      rgb_out_q  <= RGB_BLACK;
    end else if (pix_tick_i) begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  assign rgb_out  = rgb_out_q;
`else
  assign hsync    = hsync_d;
  assign vsync    = vsync_d;
  assign video_on = video_on_d;
  assign rgb_out  = rgb_out_d;
`endif

endmodule
